msg_uart_seq: RTL and testbench



---
 rtl/msg_uart_seq_pkg.sv | 23 ++
 rtl/uart_tx_serial.sv | 54 +++++
 rtl/msg_uart_seq.sv | 165 ++++++++++++++++
 tb/tb_msg_uart_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_uart_seq_pkg.sv
// Shared types and constants for the message UART sequencer.
// The built-in message image is "Hello, World! \n\r", repeated if the ROM is deeper.
package msg_uart_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    WAIT,
    CKSUM,
    FIN
  } seq_state_e;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  localparam logic [127:0] HELLO_IMAGE = 128'h48656C6C6F2C20576F726C6421200A0D;

  function automatic logic [7:0] hello_byte(input int idx);
    return HELLO_IMAGE[8*(15 - (idx % 16)) +: 8];
  endfunction

endpackage

// File: rtl/uart_tx_serial.sv
// 8N1 serializer: one write starts a frame of FRAME_BITS * CLOCKS_PER_BAUD clocks.
// o_busy rises the cycle after i_wr and falls once the stop bit has been held.
module uart_tx_serial
  import msg_uart_seq_pkg::*;
#(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_wr,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_busy,
  output logic                 o_uart_tx
);

  logic [FRAME_BITS-1:0] frame_reg;
  logic [23:0]           baud_cnt_reg;
  logic [3:0]            bit_cnt_reg;
  logic                  busy_reg;
  logic                  tx_reg;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      frame_reg    <= '1;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      busy_reg     <= 1'b0;
      tx_reg       <= 1'b1;
    end else if (!busy_reg) begin
      if (i_wr) begin
        frame_reg    <= {1'b1, i_data, 1'b0};
        tx_reg       <= 1'b0;
        busy_reg     <= 1'b1;
        baud_cnt_reg <= CLOCKS_PER_BAUD - 24'd1;
        bit_cnt_reg  <= 4'(FRAME_BITS - 1);
      end
    end else if (baud_cnt_reg != 24'd0) begin
      baud_cnt_reg <= baud_cnt_reg - 24'd1;
    end else if (bit_cnt_reg == 4'd0) begin
      // Stop bit fully held: release the line high and go idle.
      busy_reg <= 1'b0;
      tx_reg   <= 1'b1;
    end else begin
      frame_reg    <= frame_reg >> 1;
      tx_reg       <= frame_reg[1];
      bit_cnt_reg  <= bit_cnt_reg - 4'd1;
      baud_cnt_reg <= CLOCKS_PER_BAUD - 24'd1;
    end
  end

  assign o_busy    = busy_reg;
  assign o_uart_tx = tx_reg;

endmodule

// File: rtl/msg_uart_seq.sv
// Streams the first i_len bytes of the message ROM out of an 8N1 line.
// Define MSG_UART_SEQ_CKSUM_EN to append an 8-bit XOR checksum frame before o_done.
module msg_uart_seq
  import msg_uart_seq_pkg::*;
#(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868,
  parameter int          MSG_DEPTH       = 16,
  parameter              INIT_FILE       = "hello.hex",
  localparam int         LEN_W           = $clog2(MSG_DEPTH + 1),
  localparam int         IDX_W           = $clog2(MSG_DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_stb,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic [IDX_W-1:0] o_index,
  output logic             o_uart_tx
);

  // INIT_FILE names the ROM image; only the hello image is built in, others read as zero.
  localparam bit HELLO_ROM = (INIT_FILE == "hello.hex");

  seq_state_e       state_reg, state_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [IDX_W-1:0] index_reg, index_next;
  logic             abort_reg, abort_next;
  logic [7:0]       rom_mem [MSG_DEPTH];
  logic [7:0]       rom_q_reg;
  logic             ser_wr, ser_busy;
  logic [7:0]       ser_data;
  logic             start_ok, last_byte;
`ifdef MSG_UART_SEQ_CKSUM_EN
  logic [7:0]       cksum_reg, cksum_next;
  logic [1:0]       cks_phase_reg, cks_phase_next;
`endif

  for (genvar gi = 0; gi < MSG_DEPTH; gi++) begin : g_rom
    assign rom_mem[gi] = HELLO_ROM ? hello_byte(gi) : 8'h00;
  end

  always_ff @(posedge i_clk) rom_q_reg <= rom_mem[index_reg];

  assign start_ok  = i_stb && !i_abort && (i_len != '0) && (i_len <= LEN_W'(MSG_DEPTH));
  assign last_byte = (LEN_W'(index_reg) + LEN_W'(1)) == len_reg;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      index_reg     <= '0;
      abort_reg     <= 1'b0;
`ifdef MSG_UART_SEQ_CKSUM_EN
      cksum_reg     <= '0;
      cks_phase_reg <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      index_reg     <= index_next;
      abort_reg     <= abort_next;
`ifdef MSG_UART_SEQ_CKSUM_EN
      cksum_reg     <= cksum_next;
      cks_phase_reg <= cks_phase_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    index_next     = index_reg;
    abort_next     = abort_reg;
    ser_wr         = 1'b0;
    ser_data       = rom_q_reg;
`ifdef MSG_UART_SEQ_CKSUM_EN
    cksum_next     = cksum_reg;
    cks_phase_next = cks_phase_reg;
`endif
    if (state_reg != IDLE && i_abort) abort_next = 1'b1;

    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          len_next   = i_len;
          index_next = '0;
          abort_next = 1'b0;
`ifdef MSG_UART_SEQ_CKSUM_EN
          cksum_next = '0;
`endif
          state_next = FETCH;
        end
      end
      FETCH: state_next = SEND;
      SEND: begin
        ser_wr     = 1'b1;
`ifdef MSG_UART_SEQ_CKSUM_EN
        cksum_next = cksum_reg ^ rom_q_reg;
`endif
        state_next = WAIT;
      end
      WAIT: begin
        // An abort is only honoured between frames, so a frame is never cut short.
        if (!ser_busy) begin
          if (abort_next) begin
            abort_next = 1'b0;
            state_next = IDLE;
          end else if (last_byte) begin
`ifdef MSG_UART_SEQ_CKSUM_EN
            cks_phase_next = 2'd0;
            state_next     = CKSUM;
`else
            state_next = FIN;
`endif
          end else begin
            index_next = index_reg + IDX_W'(1);
            state_next = FETCH;
          end
        end
      end
`ifdef MSG_UART_SEQ_CKSUM_EN
      CKSUM: begin
        // Phase 0 mirrors FETCH so the checksum frame keeps the same inter-frame gap.
        case (cks_phase_reg)
          2'd0: cks_phase_next = 2'd1;
          2'd1: begin
            ser_wr         = 1'b1;
            ser_data       = cksum_reg;
            cks_phase_next = 2'd2;
          end
          default: begin
            if (!ser_busy) begin
              state_next = abort_next ? IDLE : FIN;
              abort_next = 1'b0;
            end
          end
        endcase
      end
`endif
      FIN: begin
        abort_next = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  uart_tx_serial #(
    .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
  ) u_serial (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_wr     (ser_wr),
    .i_data   (ser_data),
    .o_busy   (ser_busy),
    .o_uart_tx(o_uart_tx)
  );

  assign o_busy  = (state_reg != IDLE) && (state_reg != FIN);
  assign o_done  = (state_reg == FIN);
  assign o_index = index_reg;

endmodule

// File: tb/tb_msg_uart_seq.sv
// Scoreboard bench for msg_uart_seq: stimulus pushes expected frames, a line monitor decodes them.
// Honours MSG_UART_SEQ_CKSUM_EN by expecting the trailing XOR frame.
module tb_msg_uart_seq;

  localparam int CPB      = 4;
  localparam int DEPTH    = 16;
  localparam int LEN_W    = $clog2(DEPTH + 1);
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int WAVE_LEN = 10 * CPB;

  typedef struct {
    logic [7:0] data;
    int         idx;
  } exp_frame_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_stb = 1'b0;
  logic [LEN_W-1:0] i_len = '0;
  logic             i_abort = 1'b0;
  logic             o_busy, o_done, o_uart_tx;
  logic [IDX_W-1:0] o_index;

  exp_frame_t exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int exp_done = 0;
  int done_seen = 0;
  int inv_viol = 0;
  string hello_s = "Hello, World! ";

  always #5 clk = ~clk;

  msg_uart_seq #(
    .CLOCKS_PER_BAUD(24'(CPB)),
    .MSG_DEPTH      (DEPTH)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .i_stb    (i_stb),
    .i_len    (i_len),
    .i_abort  (i_abort),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_index  (o_index),
    .o_uart_tx(o_uart_tx)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_rom(input int i);
    int k = i % 16;
    if (k < 14) return hello_s[k];
    if (k == 14) return 8'h0A;
    return 8'h0D;
  endfunction

  function automatic logic [WAVE_LEN-1:0] frame_wave(input logic [7:0] b);
    logic [9:0]          fr;
    logic [WAVE_LEN-1:0] w;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < WAVE_LEN; i++) w[i] = fr[i / CPB];
    return w;
  endfunction

  task automatic push_seq(input int len);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back('{exp_rom(i), i});
      x ^= exp_rom(i);
    end
`ifdef MSG_UART_SEQ_CKSUM_EN
    exp_q.push_back('{x, len - 1});
`endif
    exp_done++;
  endtask

  // Called at a negedge; drives one start strobe and checks whether it was taken.
  task automatic start(input int len, input bit abort_too);
    bit acc = (len >= 1) && (len <= DEPTH) && !abort_too;
    if (acc) push_seq(len);
    i_len   = LEN_W'(len);
    i_stb   = 1'b1;
    i_abort = abort_too;
    @(negedge clk);
    i_stb   = 1'b0;
    i_abort = 1'b0;
    $display("start len=%0d abort=%0d accepted_expected=%0d", len, abort_too, acc);
    check("busy_after_start", o_busy, acc);
  endtask

  task automatic end_seq(input string name);
    int n = 0;
    while (o_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_timeout"}, o_busy, 0);
    repeat (4) @(negedge clk);
    check({name, "_frames_left"}, exp_q.size(), 0);
    check({name, "_done_count"}, done_seen, exp_done);
  endtask

  task automatic wait_frame_of(input int idx);
    int n = 0;
    while (!(o_index == IDX_W'(idx) && !o_uart_tx) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("frame_wait_timeout", n < 2000, 1);
  endtask

  // Line monitor: decodes each frame and compares it with the head of the scoreboard.
  initial begin
    bit                  coll = 1'b0;
    bit                  gap_on = 1'b0;
    bit                  idx_bad = 1'b0;
    int                  ns = 0;
    int                  gap = 0;
    int                  ref_gap = -1;
    logic [WAVE_LEN-1:0] wave = '0;
    logic [7:0]          got;
    exp_frame_t          cur = '{8'h00, -1};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        coll   = 1'b0;
        gap_on = 1'b0;
      end else begin
        if (!o_busy && !o_uart_tx) inv_viol++;
        if (o_busy && o_done) inv_viol++;
        if (o_done) done_seen++;
        if (coll) begin
          wave[ns] = o_uart_tx;
          if (int'(o_index) != cur.idx) idx_bad = 1'b1;
          ns++;
          if (ns == WAVE_LEN) begin
            for (int k = 0; k < 8; k++) got[k] = wave[CPB * (k + 1) + CPB / 2];
            $display("frame idx=%0d data=%02h expected=%02h", cur.idx, got, cur.data);
            check("frame_wave", wave, frame_wave(cur.data));
            check("frame_index_stable", idx_bad, 0);
            coll   = 1'b0;
            gap_on = 1'b1;
            gap    = 0;
          end
        end else if (!o_uart_tx) begin
          if (gap_on) begin
            check("gap_at_most_4", gap <= 4, 1);
            if (ref_gap < 0) ref_gap = gap;
            else check("gap_constant", gap, ref_gap);
          end
          gap_on = 1'b0;
          if (exp_q.size() == 0) begin
            check("frames_pending", exp_q.size(), 1);
            cur = '{8'h00, -1};
          end else begin
            cur = exp_q.pop_front();
          end
          idx_bad = (int'(o_index) != cur.idx);
          wave    = '0;
          ns      = 1;
          coll    = 1'b1;
        end else if (gap_on) begin
          if (o_busy) gap++;
          else gap_on = 1'b0;
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_tx", o_uart_tx, 1);
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    check("reset_index", o_index, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    start(1, 1'b0);
    end_seq("len1");
    start(16, 1'b0);
    end_seq("len16");

    start(0, 1'b0);
    repeat (30) @(negedge clk);
    start(17, 1'b0);
    repeat (30) @(negedge clk);
    end_seq("bad_len");

    start(2, 1'b0);
    repeat (20) @(negedge clk);
    i_len = LEN_W'(5);
    i_stb = 1'b1;
    @(negedge clk);
    i_stb = 1'b0;
    end_seq("stb_while_busy");

    start(4, 1'b1);
    repeat (30) @(negedge clk);
    end_seq("abort_with_start");

    start(8, 1'b0);
    wait_frame_of(3);
    repeat (10) @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    while (exp_q.size() > 0 && exp_q[$].idx > 3) void'(exp_q.pop_back());
    exp_done--;
    end_seq("abort_mid");

    for (int r = 0; r < 4; r++) begin
      int len = (r == 2) ? int'($urandom_range(17, 31)) : int'($urandom_range(1, DEPTH));
      start(len, 1'b0);
      repeat (2) @(negedge clk);
      end_seq("random");
    end

    start(4, 1'b0);
    wait_frame_of(1);
    repeat (9) @(negedge clk);
    check("tx_low_before_reset", o_uart_tx, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_tx", o_uart_tx, 1);
    check("async_reset_busy", o_busy, 0);
    check("async_reset_index", o_index, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    exp_q.delete();
    exp_done--;
    repeat (3) @(negedge clk);
    start(3, 1'b0);
    end_seq("after_reset");

    check("invariant_violations", inv_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
